// File: rtl/subarray_mac_pkg.sv
// Shared types and elaboration helpers for the SUBARRAY_MAC datapath stages.
package subarray_mac_pkg;

  typedef enum logic {
    ACC  = 1'b0,
    DONE = 1'b1
  } state_e;

  // Resolved carry-save width: the carry vector's extra weight plus the final add carry.
  function automatic int psum_res_w(input int psum_w);
    return psum_w + 2;
  endfunction

  // Ceiling log2, floored at 1 so a counter always has at least one bit.
  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return (r == 0) ? 1 : r;
  endfunction

  function automatic bit acc_w_ok(input int acc_w, input int psum_w, input int in_bits);
    return acc_w >= psum_res_w(psum_w) + in_bits;
  endfunction

endpackage

// File: rtl/psum_resolve.sv
// Carry-save to binary resolve: psum = sum + (carry << 1), full width, no truncation.
module psum_resolve
  import subarray_mac_pkg::*;
#(
  parameter int PSUM_W = 8
) (
  input  logic [PSUM_W-1:0]             in_sum,
  input  logic [PSUM_W-1:0]             in_carry,
  output logic [psum_res_w(PSUM_W)-1:0] psum
);

  localparam int RES_W = psum_res_w(PSUM_W);

  assign psum = RES_W'(in_sum) + (RES_W'(in_carry) << 1);

endmodule

// File: rtl/subarray_psum_accumulator.sv
// Shift-accumulates resolved bit-plane partial sums LSB-first and hands one MAC
// result per IN_BITS beats to the readout logic over valid/ready.
module subarray_psum_accumulator
  import subarray_mac_pkg::*;
#(
  parameter int PSUM_W    = 8,
  parameter int IN_BITS   = 8,
  parameter int ACC_W     = 20,
  parameter bit SIGNED_IN = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [PSUM_W-1:0] in_sum,
  input  logic [PSUM_W-1:0] in_carry,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ACC_W-1:0]  out_data,
  output logic              busy
);

  localparam int RES_W = psum_res_w(PSUM_W);
  localparam int IDX_W = clog2(IN_BITS);

  if (!acc_w_ok(ACC_W, PSUM_W, IN_BITS)) begin : g_acc_w_chk
    $error("ACC_W must be at least PSUM_W+2+IN_BITS");
  end
  if (IN_BITS < 2) begin : g_in_bits_chk
    $error("IN_BITS must be at least 2");
  end

  state_e            state;
  logic [IDX_W-1:0]  bit_idx;
  logic [ACC_W-1:0]  acc;
  logic [RES_W-1:0]  psum;
  logic [ACC_W-1:0]  term;
  logic [ACC_W-1:0]  acc_next;
  logic              accept;
  logic              last;

  psum_resolve #(.PSUM_W(PSUM_W)) u_resolve (
    .in_sum  (in_sum),
    .in_carry(in_carry),
    .psum    (psum)
  );

  assign in_ready = (state == ACC);
  assign busy     = (bit_idx != '0) || (state == DONE);
  assign accept   = in_valid && in_ready;
  assign last     = (bit_idx == IDX_W'(IN_BITS - 1));

  // The MSB plane of a two's-complement activation carries negative weight.
  assign term     = ACC_W'(psum) << bit_idx;
  assign acc_next = (SIGNED_IN && last) ? acc - term : acc + term;

  // NOTE: state uses non-blocking assignments so every register samples the
  // pre-edge values; blocking here would create order-dependent simulation races.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      state     <= ACC;
      bit_idx   <= '0;
      acc       <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
    end else begin
      case (state)
        ACC: begin
          if (accept) begin
            if (last) begin
              state     <= DONE;
              out_valid <= 1'b1;
              out_data  <= acc_next;
              bit_idx   <= '0;
              acc       <= '0;
            end else begin
              acc     <= acc_next;
              bit_idx <= bit_idx + 1'b1;
            end
          end
        end
        DONE: begin
          if (out_ready) begin
            state     <= ACC;
            out_valid <= 1'b0;
          end
        end
        default: state <= ACC;
      endcase
    end
  end

endmodule

// File: tb/tb_subarray_psum_accumulator.sv
// Scoreboard bench: an unsigned and a signed instance share stimulus; a cycle model
// predicts handshakes and queues expected results for comparison on out_valid.
module tb_subarray_psum_accumulator;

  localparam int PSUM_W  = 8;
  localparam int IN_BITS = 8;
  localparam int ACC_W   = 20;

  logic              clk = 1'b0;
  logic              rst;
  logic              flush;
  logic              in_valid;
  logic              out_ready;
  logic [PSUM_W-1:0] in_sum;
  logic [PSUM_W-1:0] in_carry;

  // Index 0: SIGNED_IN=0 instance, index 1: SIGNED_IN=1 instance.
  logic              ir [2];
  logic              ov [2];
  logic              bz [2];
  logic [ACC_W-1:0]  od [2];

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  subarray_psum_accumulator #(
    .PSUM_W(PSUM_W), .IN_BITS(IN_BITS), .ACC_W(ACC_W), .SIGNED_IN(1'b0)
  ) u_dut_u (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(ir[0]), .in_sum(in_sum), .in_carry(in_carry),
    .out_valid(ov[0]), .out_ready(out_ready), .out_data(od[0]), .busy(bz[0])
  );

  subarray_psum_accumulator #(
    .PSUM_W(PSUM_W), .IN_BITS(IN_BITS), .ACC_W(ACC_W), .SIGNED_IN(1'b1)
  ) u_dut_s (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(ir[1]), .in_sum(in_sum), .in_carry(in_carry),
    .out_valid(ov[1]), .out_ready(out_ready), .out_data(od[1]), .busy(bz[1])
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, obs, exp, $time);
  endtask

  // ---------------- reference model ----------------
  logic             m_done  = 1'b0;
  int               m_idx   = 0;
  int               m_beats = 0;
  logic [ACC_W-1:0] m_acc_u = '0;
  logic [ACC_W-1:0] m_acc_s = '0;
  logic [ACC_W-1:0] q_u [$];
  logic [ACC_W-1:0] q_s [$];

  function automatic logic [ACC_W-1:0] beat_term(input logic [PSUM_W-1:0] s,
                                                 input logic [PSUM_W-1:0] c, input int idx);
    logic [ACC_W-1:0] p;
    p = ACC_W'(s) + (ACC_W'(c) << 1);
    return p << idx;
  endfunction

  always @(posedge clk) begin
    if (rst || flush) begin
      m_done  <= 1'b0;
      m_idx   <= 0;
      m_acc_u <= '0;
      m_acc_s <= '0;
    end else if (!m_done) begin
      if (in_valid) begin
        m_beats <= m_beats + 1;
        if (m_idx == IN_BITS - 1) begin
          q_u.push_back(m_acc_u + beat_term(in_sum, in_carry, m_idx));
          q_s.push_back(m_acc_s - beat_term(in_sum, in_carry, m_idx));
          m_done  <= 1'b1;
          m_idx   <= 0;
          m_acc_u <= '0;
          m_acc_s <= '0;
        end else begin
          m_acc_u <= m_acc_u + beat_term(in_sum, in_carry, m_idx);
          m_acc_s <= m_acc_s + beat_term(in_sum, in_carry, m_idx);
          m_idx   <= m_idx + 1;
        end
      end
    end else if (out_ready) begin
      m_done <= 1'b0;
    end
  end

  // ---------------- output monitor ----------------
  logic             ov_prev [2] = '{1'b0, 1'b0};
  logic [ACC_W-1:0] held    [2] = '{'0, '0};

  always @(posedge clk) begin
    #1;
    for (int d = 0; d < 2; d++) begin
      logic [ACC_W-1:0] exp_v;
      check(d ? "in_ready_s"  : "in_ready_u",  ir[d], !m_done);
      check(d ? "out_valid_s" : "out_valid_u", ov[d], m_done);
      check(d ? "busy_s"      : "busy_u",      bz[d], (m_idx != 0) || m_done);
      if (ov[d] && !ov_prev[d]) begin
        check(d ? "sb_pending_s" : "sb_pending_u", d ? q_s.size() : q_u.size(), 1);
        if ((d ? q_s.size() : q_u.size()) != 0) begin
          exp_v = d ? q_s.pop_front() : q_u.pop_front();
          check(d ? "result_s" : "result_u", od[d], exp_v);
          held[d] <= exp_v;
        end
      end else if (ov[d]) begin
        check(d ? "hold_s" : "hold_u", od[d], held[d]);
      end
      ov_prev[d] <= ov[d];
    end
  end

  // ---------------- stimulus ----------------
  task automatic idle(input int n);
    in_valid = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  task automatic send_beat(input logic [PSUM_W-1:0] s, input logic [PSUM_W-1:0] c);
    int start;
    start    = m_beats;
    in_valid = 1'b1;
    in_sum   = s;
    in_carry = c;
    for (int i = 0; i < 40 && m_beats == start; i++) @(negedge clk);
    if (m_beats == start) check("beat_accept_timeout", 0, 1);
  endtask

  task automatic send_op(input logic [PSUM_W-1:0] s [IN_BITS],
                         input logic [PSUM_W-1:0] c [IN_BITS], input bit gaps);
    for (int i = 0; i < IN_BITS; i++) begin
      send_beat(s[i], c[i]);
      if (gaps && $urandom_range(0, 1) == 1) idle($urandom_range(1, 3));
    end
  endtask

  task automatic send_const(input logic [PSUM_W-1:0] s, input logic [PSUM_W-1:0] c);
    logic [PSUM_W-1:0] ss [IN_BITS];
    logic [PSUM_W-1:0] cc [IN_BITS];
    for (int i = 0; i < IN_BITS; i++) begin
      ss[i] = s;
      cc[i] = c;
    end
    send_op(ss, cc, 1'b0);
  endtask

  task automatic wait_drained();
    in_valid = 1'b0;
    for (int i = 0; i < 40 && m_done; i++) @(negedge clk);
    if (m_done) check("drain_timeout", 0, 1);
    @(negedge clk);
  endtask

  task automatic pulse(input bit use_flush);
    in_valid = 1'b0;
    if (use_flush) flush = 1'b1; else rst = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    rst   = 1'b0;
  endtask

  initial begin
    logic [PSUM_W-1:0] ss [IN_BITS];
    logic [PSUM_W-1:0] cc [IN_BITS];

    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    in_sum = '0; in_carry = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    check("reset_data_u", od[0], '0);
    check("reset_data_s", od[1], '0);

    // Ones on every plane: 255 unsigned, -1 signed.
    send_const(8'd1, 8'd0);
    wait_drained();

    // Carry weighting on plane 0 only: 2 for both.
    for (int i = 0; i < IN_BITS; i++) begin
      ss[i] = '0;
      cc[i] = '0;
    end
    cc[0] = 8'd1;
    send_op(ss, cc, 1'b0);
    wait_drained();

    // Full-scale carry-save pairs: psum 765 on every plane.
    send_const(8'd255, 8'd255);
    wait_drained();

    // Backpressure with in_valid held high through DONE.
    out_ready = 1'b0;
    fork
      begin
        send_const(8'd1, 8'd0);
        send_const(8'd1, 8'd0);
      end
      begin
        for (int i = 0; i < 40 && !m_done; i++) @(negedge clk);
        repeat (5) @(negedge clk);
        out_ready = 1'b1;
      end
    join
    wait_drained();

    // Random operands with random gaps.
    for (int k = 0; k < 3; k++) begin
      for (int i = 0; i < IN_BITS; i++) begin
        ss[i] = PSUM_W'($urandom);
        cc[i] = PSUM_W'($urandom);
      end
      send_op(ss, cc, 1'b1);
      wait_drained();
    end

    // Reset, then flush, after three accepted beats; then a clean operation.
    for (int f = 0; f < 2; f++) begin
      for (int i = 0; i < 3; i++) send_beat(8'd3, 8'd1);
      pulse(f == 1);
      send_const(8'd1, 8'd0);
      wait_drained();
    end

    // Flush in the same cycle as a beat: beat is discarded.
    send_beat(8'd5, 8'd0);
    send_beat(8'd5, 8'd0);
    in_valid = 1'b1;
    flush    = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    idle(1);
    send_const(8'd1, 8'd0);
    wait_drained();

    // Flush while a result is held.
    out_ready = 1'b0;
    send_const(8'd7, 8'd2);
    idle(2);
    pulse(1'b1);
    idle(2);
    out_ready = 1'b1;
    send_const(8'd1, 8'd0);
    wait_drained();

    check("sb_empty_u", q_u.size(), 0);
    check("sb_empty_s", q_s.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
